// File: rtl/fetch_sequencer_if.sv
// Signal bundle between the fetch sequencer, its control sources, the
// instruction memory and decode.
interface fetch_sequencer_if;
  logic        start;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fault;

  modport master (
    input  start, halt, redirect_valid, redirect_pc, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst, inst_pc, fault
  );

  modport slave (
    output start, halt, redirect_valid, redirect_pc, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, fault
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: credit-limited word fetch into a 2-entry queue
// feeding decode over valid/ready, with redirect, halt and range-fault handling.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 21
) (
  input logic               clk,
  input logic               rst_n,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fault_q, fault_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] head_inst_q, head_inst_d;
  logic [31:0] head_pc_q, head_pc_d;
  logic [31:0] tail_inst_q, tail_inst_d;
  logic [31:0] tail_pc_q, tail_pc_d;

  logic        pop;
  logic        try_issue;
  logic        addr_bad;
  logic        issue;
  logic [31:0] cand_addr;
  logic [2:0]  committed;

  // Slots already spoken for once this cycle's pop is accounted for.
  always_comb begin
    pop       = (count_q != 2'd0) && bus.inst_ready;
    cand_addr = bus.redirect_valid ? bus.redirect_pc : pc_q;
    committed = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    try_issue = (state_q == ST_RUN) && !bus.halt &&
                (bus.redirect_valid || (committed < 3'd2));
    addr_bad  = (cand_addr >= ADDR_LIMIT) || (cand_addr[1:0] != 2'b00);
    issue     = try_issue && !addr_bad;
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fault_d       = fault_q;
    inflight_d    = issue;
    inflight_pc_d = cand_addr;

    if (bus.redirect_valid) begin
      pc_d = bus.redirect_pc;
    end
    if (issue) begin
      pc_d = cand_addr + 32'd4;
    end
    if (try_issue && addr_bad) begin
      fault_d = 1'b1;
    end

    case (state_q)
      ST_IDLE:   if (bus.start) state_d = ST_RUN;
      ST_RUN:    if (bus.halt) state_d = ST_HALTED;
      ST_HALTED: if (bus.start && !fault_q) state_d = ST_RUN;
      default:   state_d = ST_IDLE;
    endcase
    if (fault_d) begin
      state_d = ST_HALTED;
    end
  end

  // The returning word is dropped on redirect; otherwise it joins the tail
  // after any pop, so the queue shifts toward the head.
  always_comb begin
    count_d     = count_q;
    head_inst_d = head_inst_q;
    head_pc_d   = head_pc_q;
    tail_inst_d = tail_inst_q;
    tail_pc_d   = tail_pc_q;

    if (bus.redirect_valid) begin
      count_d = 2'd0;
    end else begin
      case ({inflight_q, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_inst_d = bus.imem_rdata;
            head_pc_d   = inflight_pc_q;
          end else begin
            tail_inst_d = bus.imem_rdata;
            tail_pc_d   = inflight_pc_q;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_inst_d = tail_inst_q;
          head_pc_d   = tail_pc_q;
          count_d     = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            head_inst_d = tail_inst_q;
            head_pc_d   = tail_pc_q;
            tail_inst_d = bus.imem_rdata;
            tail_pc_d   = inflight_pc_q;
          end else begin
            head_inst_d = bus.imem_rdata;
            head_pc_d   = inflight_pc_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      fault_q       <= 1'b0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
      count_q       <= 2'd0;
      head_inst_q   <= 32'd0;
      head_pc_q     <= 32'd0;
      tail_inst_q   <= 32'd0;
      tail_pc_q     <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fault_q       <= fault_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      head_inst_q   <= head_inst_d;
      head_pc_q     <= head_pc_d;
      tail_inst_q   <= tail_inst_d;
      tail_pc_q     <= tail_pc_d;
    end
  end

  assign bus.imem_req   = issue;
  assign bus.imem_addr  = cand_addr;
  assign bus.inst_valid = (count_q != 2'd0);
  assign bus.inst       = head_inst_q;
  assign bus.inst_pc    = head_pc_q;
  assign bus.fault      = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed and randomised bench for fetch_sequencer; the reference tracks
// outstanding fetches and queued words as PC lists plus an operating mode.
module tb_fetch_sequencer;
  localparam int          MEM_WORDS = 21;
  localparam logic [31:0] LIMIT     = 32'(4 * MEM_WORDS);
  localparam int          M_IDLE = 0, M_RUN = 1, M_HALT = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] stream_pc;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_PC(32'h0), .MEM_WORDS(MEM_WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: mode, PC, sticky fault, queued PCs and the PC fetched last cycle.
  int          m_state;
  logic [31:0] m_pc;
  logic        m_fault;
  logic [31:0] m_queue[$];
  logic [31:0] m_infl[$];
  logic        exp_req, exp_valid, exp_try, exp_bad;
  logic [31:0] exp_addr, exp_pc;

  function automatic logic [31:0] memword(logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  function automatic void model_reset();
    m_state = M_IDLE;
    m_pc    = 32'h0;
    m_fault = 1'b0;
    m_queue.delete();
    m_infl.delete();
  endfunction

  function automatic void model_eval();
    int   outstanding;
    logic pop;
    exp_valid   = (m_queue.size() != 0);
    exp_pc      = exp_valid ? m_queue[0] : 32'h0;
    pop         = exp_valid && bus.inst_ready;
    outstanding = m_queue.size() + m_infl.size() - (pop ? 1 : 0);
    exp_addr    = bus.redirect_valid ? bus.redirect_pc : m_pc;
    exp_try     = (m_state == M_RUN) && !bus.halt && (bus.redirect_valid || outstanding < 2);
    exp_bad     = (exp_addr >= LIMIT) || (exp_addr % 4 != 0);
    exp_req     = exp_try && !exp_bad;
  endfunction

  function automatic void model_step();
    model_eval();
    if (exp_valid && bus.inst_ready) void'(m_queue.pop_front());
    if (bus.redirect_valid) m_queue.delete();
    else if (m_infl.size() != 0) m_queue.push_back(m_infl[0]);
    m_infl.delete();
    if (exp_req) m_infl.push_back(exp_addr);
    if (bus.redirect_valid) m_pc = bus.redirect_pc;
    if (exp_req) m_pc = exp_addr + 32'd4;
    if (exp_try && exp_bad) m_fault = 1'b1;
    case (m_state)
      M_IDLE:  if (bus.start) m_state = M_RUN;
      M_RUN:   if (bus.halt) m_state = M_HALT;
      default: if (bus.start && !m_fault) m_state = M_RUN;
    endcase
    if (m_fault) m_state = M_HALT;
  endfunction

  task automatic settle();
    #1;
    model_eval();
  endtask

  // Advance one clock; the memory returns the addressed word the cycle after a request.
  task automatic run_cycle();
    logic        req_s;
    logic [31:0] addr_s;
    model_step();
    req_s  = bus.imem_req;
    addr_s = bus.imem_addr;
    if (bus.inst_valid && bus.inst_ready)
      $display("[TB] xfer pc=%08h inst=%08h", bus.inst_pc, bus.inst);
    @(posedge clk);
    @(negedge clk);
    bus.imem_rdata     = req_s ? memword(addr_s) : 32'hDEAD_BEEF;
    bus.start          = 1'b0;
    bus.redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.start          = 1'b0;
    bus.halt           = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.inst_ready     = 1'b0;
    bus.imem_rdata     = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    n_tests++;
    if ({bus.imem_req, bus.inst_valid, bus.fault} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: req/valid/fault=%b%b%b want 000", bus.imem_req, bus.inst_valid, bus.fault);
    end
    n_tests++;
    if (bus.imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_addr: got %08h want 00000000", bus.imem_addr);
    end
    n_tests++;
    if (bus.inst !== 32'h0 || bus.inst_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_inst: inst=%08h pc=%08h want 0/0", bus.inst, bus.inst_pc);
    end
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      settle();
      n_tests++;
      if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_idle: cycle %0d req=%b valid=%b want 0/0", i, bus.imem_req, bus.inst_valid);
      end
    end
  endtask

  task automatic test_stream();
    do_reset();
    bus.inst_ready = 1'b1;
    bus.start      = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      settle();
      n_tests++;
      if (bus.imem_req !== (c >= 1)) begin
        n_fail++; $display("FAIL stream_req: cycle %0d got %b want %b", c, bus.imem_req, (c >= 1));
      end
      if (c >= 1) begin
        n_tests++;
        if (bus.imem_addr !== 32'(4 * (c - 1))) begin
          n_fail++; $display("FAIL stream_addr: cycle %0d got %08h want %08h", c, bus.imem_addr, 32'(4 * (c - 1)));
        end
      end
      n_tests++;
      if (bus.inst_valid !== (c >= 3)) begin
        n_fail++; $display("FAIL stream_valid: cycle %0d got %b want %b", c, bus.inst_valid, (c >= 3));
      end
      if (c >= 3) begin
        n_tests++;
        if (bus.inst_pc !== 32'(4 * (c - 3)) || bus.inst !== 32'h1000_0000 + 32'(c - 3)) begin
          n_fail++; $display("FAIL stream_data: cycle %0d got pc=%08h inst=%08h want pc=%08h inst=%08h",
                             c, bus.inst_pc, bus.inst, 32'(4 * (c - 3)), 32'h1000_0000 + 32'(c - 3));
        end
      end
      run_cycle();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] next_pc;
    bus.inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      n_tests++;
      if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h20 || bus.inst !== memword(32'h20)) begin
        n_fail++; $display("FAIL bp_hold: stall %0d req=%b valid=%b pc=%08h inst=%08h want 0/1/00000020/%08h",
                           i, bus.imem_req, bus.inst_valid, bus.inst_pc, bus.inst, memword(32'h20));
      end
      run_cycle();
    end
    bus.inst_ready = 1'b1;
    next_pc = 32'h20;
    for (int i = 0; i < 8; i++) begin
      settle();
      n_tests++;
      if (bus.inst_valid !== 1'b1 || bus.inst_pc !== next_pc || bus.inst !== memword(next_pc)) begin
        n_fail++; $display("FAIL bp_resume: beat %0d valid=%b pc=%08h want 1/%08h", i, bus.inst_valid, bus.inst_pc, next_pc);
      end
      next_pc += 32'd4;
      run_cycle();
    end
  endtask

  task automatic test_redirect();
    logic found;
    do_reset();
    bus.inst_ready = 1'b1;
    bus.start      = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      settle();
      if (bus.imem_req === 1'b1 && bus.imem_addr === 32'h0C) found = 1'b1;
      else run_cycle();
    end
    n_tests++;
    if (!found) begin
      n_fail++; $display("FAIL redir_sync: request at 0000000c got none within 10 cycles want one");
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h20;
    settle();
    n_tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h20) begin
      n_fail++; $display("FAIL redir_issue: req=%b addr=%08h want 1/00000020", bus.imem_req, bus.imem_addr);
    end
    run_cycle();
    settle();
    n_tests++;
    if (bus.inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_stale: valid=%b pc=%08h want valid 0", bus.inst_valid, bus.inst_pc);
    end
    run_cycle();
    stream_pc = 32'h20;
    for (int i = 0; i < 6; i++) begin
      settle();
      n_tests++;
      if (bus.inst_valid !== 1'b1 || bus.inst_pc !== stream_pc || bus.inst !== memword(stream_pc)) begin
        n_fail++; $display("FAIL redir_stream: beat %0d valid=%b pc=%08h want 1/%08h", i, bus.inst_valid, bus.inst_pc, stream_pc);
      end
      stream_pc += 32'd4;
      run_cycle();
    end
  endtask

  task automatic test_halt();
    logic [31:0] p;
    p = stream_pc;
    bus.halt = 1'b1;
    settle();
    n_tests++;
    if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b1 || bus.inst_pc !== p) begin
      n_fail++; $display("FAIL halt_first: req=%b valid=%b pc=%08h want 0/1/%08h", bus.imem_req, bus.inst_valid, bus.inst_pc, p);
    end
    run_cycle();
    settle();
    n_tests++;
    if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b1 || bus.inst_pc !== p + 32'd4) begin
      n_fail++; $display("FAIL halt_drain: req=%b valid=%b pc=%08h want 0/1/%08h", bus.imem_req, bus.inst_valid, bus.inst_pc, p + 32'd4);
    end
    run_cycle();
    for (int i = 0; i < 3; i++) begin
      settle();
      n_tests++;
      if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0) begin
        n_fail++; $display("FAIL halt_quiet: cycle %0d req=%b valid=%b want 0/0", i, bus.imem_req, bus.inst_valid);
      end
      run_cycle();
    end
    bus.halt  = 1'b0;
    bus.start = 1'b1;
    settle();
    n_tests++;
    if (bus.imem_req !== 1'b0) begin
      n_fail++; $display("FAIL halt_start_cycle: req=%b want 0", bus.imem_req);
    end
    run_cycle();
    settle();
    n_tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== p + 32'd8) begin
      n_fail++; $display("FAIL halt_resume_req: req=%b addr=%08h want 1/%08h", bus.imem_req, bus.imem_addr, p + 32'd8);
    end
    run_cycle();
    run_cycle();
    settle();
    n_tests++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== p + 32'd8) begin
      n_fail++; $display("FAIL halt_resume_data: valid=%b pc=%08h want 1/%08h", bus.inst_valid, bus.inst_pc, p + 32'd8);
    end
  endtask

  task automatic test_fault();
    logic [31:0] next_pc;
    int          delivered;
    do_reset();
    bus.inst_ready = 1'b1;
    bus.start      = 1'b1;
    next_pc   = 32'h0;
    delivered = 0;
    for (int i = 0; i < 40; i++) begin
      settle();
      if (bus.imem_req === 1'b1) begin
        n_tests++;
        if (bus.imem_addr >= LIMIT) begin
          n_fail++; $display("FAIL fault_range: request at %08h want below %08h", bus.imem_addr, LIMIT);
        end
      end
      if (bus.inst_valid === 1'b1) begin
        n_tests++;
        if (bus.inst_pc !== next_pc) begin
          n_fail++; $display("FAIL fault_order: got pc=%08h want %08h", bus.inst_pc, next_pc);
        end
        next_pc += 32'd4;
        delivered++;
      end
      run_cycle();
    end
    settle();
    n_tests++;
    if (delivered != MEM_WORDS || bus.fault !== 1'b1 || bus.inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL fault_end: delivered=%0d fault=%b valid=%b want %0d/1/0", delivered, bus.fault, bus.inst_valid, MEM_WORDS);
    end
    bus.start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      n_tests++;
      if (bus.imem_req !== 1'b0 || bus.fault !== 1'b1) begin
        n_fail++; $display("FAIL fault_start: cycle %0d req=%b fault=%b want 0/1", i, bus.imem_req, bus.fault);
      end
      run_cycle();
    end

    do_reset();
    settle();
    n_tests++;
    if (bus.fault !== 1'b0) begin
      n_fail++; $display("FAIL fault_clear: fault=%b want 0", bus.fault);
    end
    bus.inst_ready = 1'b1;
    bus.start      = 1'b1;
    run_cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = LIMIT - 32'd4;
    settle();
    n_tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== LIMIT - 32'd4) begin
      n_fail++; $display("FAIL fault_last_legal: req=%b addr=%08h want 1/%08h", bus.imem_req, bus.imem_addr, LIMIT - 32'd4);
    end
    run_cycle();
    settle();
    n_tests++;
    if (bus.imem_req !== 1'b0) begin
      n_fail++; $display("FAIL fault_limit_req: req=%b addr=%08h want no request", bus.imem_req, bus.imem_addr);
    end
    run_cycle();
    settle();
    n_tests++;
    if (bus.fault !== 1'b1 || bus.inst_valid !== 1'b1 || bus.inst_pc !== LIMIT - 32'd4) begin
      n_fail++; $display("FAIL fault_limit_drain: fault=%b valid=%b pc=%08h want 1/1/%08h", bus.fault, bus.inst_valid, bus.inst_pc, LIMIT - 32'd4);
    end

    do_reset();
    bus.inst_ready = 1'b1;
    bus.start      = 1'b1;
    run_cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h06;
    settle();
    n_tests++;
    if (bus.imem_req !== 1'b0) begin
      n_fail++; $display("FAIL fault_misalign_req: req=%b want 0", bus.imem_req);
    end
    run_cycle();
    settle();
    n_tests++;
    if (bus.fault !== 1'b1) begin
      n_fail++; $display("FAIL fault_misalign: fault=%b want 1", bus.fault);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.inst_ready = 1'b0;
    bus.start      = 1'b1;
    for (int i = 0; i < 5; i++) run_cycle();
    settle();
    n_tests++;
    if (bus.inst_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
      n_fail++; $display("FAIL rmid_fill: valid=%b req=%b want 1/0", bus.inst_valid, bus.imem_req);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.fault !== 1'b0) begin
      n_fail++; $display("FAIL rmid_async: valid=%b req=%b fault=%b want 0/0/0", bus.inst_valid, bus.imem_req, bus.fault);
    end
    model_reset();
    @(negedge clk);
    rst_n          = 1'b1;
    bus.imem_rdata = 32'h1234_5678;
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_tests++;
      if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0) begin
        n_fail++; $display("FAIL rmid_idle: cycle %0d req=%b valid=%b want 0/0", i, bus.imem_req, bus.inst_valid);
      end
      run_cycle();
    end
    bus.start = 1'b1;
    run_cycle();
    settle();
    n_tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL rmid_restart: req=%b addr=%08h want 1/00000000", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_random();
    do_reset();
    bus.inst_ready = 1'b1;
    bus.start      = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (m_fault && m_queue.size() == 0 && m_infl.size() == 0) begin
        do_reset();
        bus.start = 1'b1;
      end
      bus.inst_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) bus.halt = ~bus.halt;
      if ($urandom_range(0, 24) == 0) bus.start = 1'b1;
      if ($urandom_range(0, 9) == 0) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 100))
                                                         : 32'(4 * $urandom_range(0, MEM_WORDS - 1));
      end
      settle();
      n_tests++;
      if (bus.imem_req !== exp_req || (exp_req && bus.imem_addr !== exp_addr)) begin
        n_fail++; $display("FAIL rand_req: cycle %0d req=%b addr=%08h want %b/%08h", i, bus.imem_req, bus.imem_addr, exp_req, exp_addr);
      end
      n_tests++;
      if (bus.inst_valid !== exp_valid || (exp_valid && (bus.inst_pc !== exp_pc || bus.inst !== memword(exp_pc)))) begin
        n_fail++; $display("FAIL rand_head: cycle %0d valid=%b pc=%08h inst=%08h want %b/%08h/%08h",
                           i, bus.inst_valid, bus.inst_pc, bus.inst, exp_valid, exp_pc, memword(exp_pc));
      end
      n_tests++;
      if (bus.fault !== m_fault) begin
        n_fail++; $display("FAIL rand_fault: cycle %0d got %b want %b", i, bus.fault, m_fault);
      end
      run_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_fault();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller sitting between the program counter logic and the word-addressed instruction memory. It issues at most one word read per cycle and buffers returned instructions in a 2-entry queue. It hands them to decode over a valid/ready handshake and handles redirects (branch/jump), halt and out-of-range fetch faults. Supports one instruction per cycle when decode is always ready.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after `start`; must be word-aligned.
- `MEM_WORDS`, 21, instruction memory depth in 32-bit words; legal byte addresses are 0 .. 4*MEM_WORDS-4.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; leaves IDLE/HALTED and begins fetching at the current PC.
- `halt`  in  1  level; while high, no new requests are issued.
- `redirect_valid`  in  1  redirect PC this cycle.
- `redirect_pc`  in  32  redirect target (byte address).
- `imem_req`  out  1  read strobe to memory.
- `imem_addr`  out  32  byte address of the read; bits [1:0] always 0.
- `imem_rdata`  in  32  read data, valid exactly one cycle after `imem_req`.
- `inst_valid`  out  1  queue head valid.
- `inst_ready`  in  1  decode accepts the head.
- `inst`  out  32  instruction at the queue head.
- `inst_pc`  out  32  byte address of `inst`.
- `fault`  out  1  sticky; set on an out-of-range or misaligned fetch address.

## Operation
- FSM states are IDLE, RUN and HALTED. Reset enters IDLE.
- IDLE: `start` goes to RUN, with PC = `RESET_PC`.
- RUN with `halt` high goes to HALTED.
- HALTED with `start` goes to RUN, but only if `fault` = 0.
- A fault in any state goes to HALTED.
- Transfer rule: a transfer occurs when `inst_valid` && `inst_ready`; this pops the queue head.
- Credit rule: in RUN with `halt`=0, issue a request iff (queue occupancy + in-flight − pop this cycle) < 2.
- On issue, PC <= PC+4. `imem_addr` is driven combinationally from the PC, or from `redirect_pc` in a redirect cycle.
- Response: the cycle after issue, `imem_rdata` and its PC are written to the queue tail, unless that response is killed.
- Redirect has priority over everything else:
  - It flushes the queue.
  - It kills the response returning this cycle.
  - The PC becomes `redirect_pc`.
  - In RUN (`halt`=0), a request at `redirect_pc` is issued in the same cycle, and PC <= `redirect_pc`+4.
  - A head accepted in the redirect cycle still counts as transferred.
- Redirect in IDLE/HALTED only loads the PC; the state is unchanged.
- Halt behaviour:
  - No new issue.
  - An in-flight response still lands in the queue.
  - The queue drains normally to decode.
- Fault:
  - Raised when a candidate issue address is ≥ 4*MEM_WORDS or has [1:0] ≠ 0.
  - The request is suppressed, `fault` <= 1, and the state goes to HALTED.
  - Queued and in-flight instructions still drain.
  - `fault` clears only on reset.
- PC arithmetic is 32-bit modulo. Wrap past 4*MEM_WORDS is caught by the fault check before reaching memory.

## Timing
- Reset values:
  - State IDLE, PC = `RESET_PC`, queue empty, nothing in flight.
  - `imem_req`=0, `imem_addr`=`RESET_PC`, `inst_valid`=0, `inst`=0, `inst_pc`=0, `fault`=0.
- Latency: `start` at cycle N gives `imem_req` at N+1 with address `RESET_PC`. Data returns at N+2, and `inst_valid` is high at N+3.
- Request-to-`inst_valid` latency is 2 cycles. With `inst_ready` held high, throughput is 1 instruction/cycle.
- Redirect at cycle R: first valid instruction at `redirect_pc` appears at R+2. No stale instruction is visible at R+1 or later.
- Backpressure: with `inst_ready`=0, at most 2 instructions are held. `imem_req` stays low when occupancy+in-flight = 2.
- `inst`/`inst_pc` are stable while `inst_valid`=1 and `inst_ready`=0.
- `rst_n` assertion mid-operation:
  - Immediately clears the queue, in-flight tracking and `fault`.
  - Forces `imem_req`=0.
  - Any memory response arriving after deassertion is ignored.

## Test plan
- Streaming:
  - Stimulus: reset, `start` pulse, `inst_ready`=1, memory word k = 32'h1000_0000+k.
  - Required: `inst` sequence 1000_0000, 1000_0001, … with `inst_pc` 0, 4, 8 on consecutive cycles from `start`+3.
- Backpressure:
  - Stimulus: `inst_ready`=0 for 5 cycles mid-stream.
  - Required: `imem_req` low after 2 outstanding, head held stable, then stream resumes with no skipped or duplicated PC.
- Redirect:
  - Stimulus: `redirect_valid` with `redirect_pc`=0x20 while streaming at PC 0x0C.
  - Required: in-flight 0x0C dropped, next `inst_pc` seen is 0x20 exactly 2 cycles later.
- Halt:
  - Stimulus: `halt`=1 during streaming.
  - Required: no further `imem_req`, already issued words delivered in order, `inst_valid` then low. `start` with `halt`=0 resumes at the next PC.
- Fault:
  - Stimulus: `MEM_WORDS`=4, stream from 0.
  - Required: PCs 0, 4, 8, 0xC delivered, no request at 0x10, `fault`=1, state HALTED, and `start` has no effect.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 with 2 queued entries.
  - Required: `inst_valid`=0 and `imem_req`=0 asynchronously, state IDLE after release.
